// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and owner tags.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;
endpackage

// File: rtl/mem_port_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
interface mem_port_arb_if #(parameter int AW = 32, parameter int DW = 32);
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
    output c_gnt, c_rvalid, d_gnt, d_rvalid, rdata, m_en, m_we, m_addr, m_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  c_gnt, c_rvalid, d_gnt, d_rvalid, rdata, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arb_starve_cnt.sv
// Saturating counter of consecutive core grants taken while the loader waits.
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CW = $clog2(MAX + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && !at_max)       cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == CW'(MAX));
endmodule

// File: rtl/mem_port_arb.sv
// Core/loader arbiter for the single memory port: grant, fixed-latency access, response.
module mem_port_arb
  import arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.slave  bus
);
  localparam int LW = $clog2(MEM_LAT + 1);

  state_t        state, nxt;
  logic [LW-1:0] lat_cnt;
  logic          own, cap_we, starve_max, pick_d, grant, last, sel_we;
  logic          m_en_q, m_we_q, c_rv_q, d_rv_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q, rdata_q;

  always_comb begin
    pick_d = bus.d_req && (!bus.c_req || starve_max);
    // gated by rst so grants stay low while the block is held in reset
    grant  = rst && (state == IDLE) && (bus.c_req || bus.d_req);
    sel_we = pick_d ? bus.d_we : bus.c_we;
    last   = (lat_cnt == LW'(MEM_LAT - 1));
    nxt    = state;
    case (state)
      IDLE:    if (grant) nxt = ACCESS;
      ACCESS:  if (last)  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      own       <= OWN_CORE;
      cap_we    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      c_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
    end else begin
      state   <= nxt;
      lat_cnt <= (state == ACCESS && !last) ? lat_cnt + 1'b1 : '0;
      if (grant) begin
        own       <= pick_d ? OWN_LDR : OWN_CORE;
        cap_we    <= sel_we;
        m_addr_q  <= pick_d ? bus.d_addr  : bus.c_addr;
        m_wdata_q <= pick_d ? bus.d_wdata : bus.c_wdata;
      end
      if (state == ACCESS && last && !cap_we) rdata_q <= bus.m_rdata;
      m_en_q <= (nxt == ACCESS);
      m_we_q <= (nxt == ACCESS) && (grant ? sel_we : cap_we);
      c_rv_q <= (nxt == RESP) && (own == OWN_CORE);
      d_rv_q <= (nxt == RESP) && (own == OWN_LDR);
    end
  end

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant && !pick_d && bus.d_req),
    .clr    ((grant && pick_d) || (state == IDLE && !bus.d_req)),
    .at_max (starve_max)
  );

  assign bus.c_gnt    = grant && !pick_d;
  assign bus.d_gnt    = grant && pick_d;
  assign bus.c_rvalid = c_rv_q;
  assign bus.d_rvalid = d_rv_q;
  assign bus.rdata    = rdata_q;
  assign bus.m_en     = m_en_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus a randomized run against a timeline model.
module tb_mem_port_arb;
  localparam int L  = 3;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arb_if #(.AW(32), .DW(32)) b3 ();
  mem_port_arb_if #(.AW(32), .DW(32)) b1 ();

  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(L), .STARVE_MAX(SM)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SM)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic cg, dg, crv, drv, en, we;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  // timeline model: each grant at cycle g_t owns the port until g_t+L+1
  int          mt, free_at, g_t, sv;
  bit          got, g_own, g_we;
  logic [31:0] g_addr, g_wdata, rd_exp;

  task automatic model_clear();
    mt = 0; free_at = 0; g_t = 0; sv = 0; got = 0;
    g_own = 0; g_we = 0; g_addr = 0; g_wdata = 0; rd_exp = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit idle, pd;
    idle = (mt >= free_at);
    pd   = b3.d_req && (!b3.c_req || sv == SM);
    e = '0;
    e.cg    = idle && b3.c_req && !pd;
    e.dg    = idle && pd;
    e.en    = got && mt > g_t && mt <= g_t + L;
    e.we    = e.en && g_we;
    e.addr  = g_addr;
    e.wdata = g_wdata;
    e.crv   = got && mt == g_t + L + 1 && !g_own;
    e.drv   = got && mt == g_t + L + 1 && g_own;
    e.rdata = rd_exp;
    if (e.en && mt == g_t + L && !g_we) rd_exp = b3.m_rdata;
    if (e.dg) sv = 0;
    else if (idle && !b3.d_req) sv = 0;
    else if (e.cg && sv < SM) sv++;
    if (e.cg || e.dg) begin
      g_t = mt; got = 1; free_at = mt + L + 2; g_own = e.dg;
      g_we    = e.dg ? b3.d_we    : b3.c_we;
      g_addr  = e.dg ? b3.d_addr  : b3.c_addr;
      g_wdata = e.dg ? b3.d_wdata : b3.c_wdata;
    end
    mt++;
  endtask

  task automatic idle_inputs();
    b3.c_req = 0; b3.c_we = 0; b3.c_addr = 0; b3.c_wdata = 0;
    b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0; b3.m_rdata = 0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = 0; b1.c_wdata = 0;
    b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.m_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs();
    b3.c_req = 1; b3.d_req = 1;
    @(negedge clk);
    total++;
    if ({b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we} !== 6'b0 ||
        b3.m_addr !== 0 || b3.m_wdata !== 0 || b3.rdata !== 0) begin
      bad++; $display("FAIL reset_l3: ctl=%b addr=%h wdata=%h rdata=%h want all 0",
        {b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we}, b3.m_addr, b3.m_wdata, b3.rdata);
    end
    total++;
    if ({b1.c_gnt, b1.d_gnt, b1.c_rvalid, b1.d_rvalid, b1.m_en, b1.m_we} !== 6'b0 ||
        b1.m_addr !== 0 || b1.rdata !== 0) begin
      bad++; $display("FAIL reset_l1: ctl=%b addr=%h rdata=%h want all 0",
        {b1.c_gnt, b1.d_gnt, b1.c_rvalid, b1.d_rvalid, b1.m_en, b1.m_we}, b1.m_addr, b1.rdata);
    end
  endtask

  task automatic test_lat1_read();
    do_reset();
    b1.m_rdata = 32'hDEADBEEF;
    b1.c_req = 1; b1.c_we = 0; b1.c_addr = 32'h10;
    @(negedge clk); total++;
    if (b1.c_gnt !== 1 || b1.d_gnt !== 0 || b1.m_en !== 0) begin
      bad++; $display("FAIL lat1_c0: c_gnt=%b d_gnt=%b m_en=%b want 1 0 0", b1.c_gnt, b1.d_gnt, b1.m_en);
    end
    tick(); b1.c_req = 0;
    @(negedge clk); total++;
    if (b1.m_en !== 1 || b1.m_we !== 0 || b1.m_addr !== 32'h10 || b1.c_rvalid !== 0) begin
      bad++; $display("FAIL lat1_c1: m_en=%b m_we=%b m_addr=%h rv=%b want 1 0 10 0", b1.m_en, b1.m_we, b1.m_addr, b1.c_rvalid);
    end
    tick();
    @(negedge clk); total++;
    if (b1.c_rvalid !== 1 || b1.rdata !== 32'hDEADBEEF || b1.m_en !== 0) begin
      bad++; $display("FAIL lat1_c2: rv=%b rdata=%h m_en=%b want 1 deadbeef 0", b1.c_rvalid, b1.rdata, b1.m_en);
    end
    tick();
    @(negedge clk); total++;
    if (b1.c_rvalid !== 0 || b1.c_gnt !== 0) begin
      bad++; $display("FAIL lat1_c3: rv=%b gnt=%b want 0 0", b1.c_rvalid, b1.c_gnt);
    end
  endtask

  task automatic test_ldr_write();
    do_reset();
    b3.m_rdata = 32'h12345678;
    b3.c_req = 1; b3.c_we = 0; b3.c_addr = 32'h4;
    tick(); b3.c_req = 0;
    repeat (L + 1) tick();
    b3.m_rdata = 32'hFFFFFFFF;
    b3.d_req = 1; b3.d_we = 1; b3.d_addr = 32'h20; b3.d_wdata = 32'h5A;
    @(negedge clk); total++;
    if (b3.d_gnt !== 1 || b3.c_gnt !== 0 || b3.rdata !== 32'h12345678) begin
      bad++; $display("FAIL wr_gnt: d_gnt=%b c_gnt=%b rdata=%h want 1 0 12345678", b3.d_gnt, b3.c_gnt, b3.rdata);
    end
    tick(); b3.d_req = 0;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk); total++;
      if (b3.m_en !== 1 || b3.m_we !== 1 || b3.m_addr !== 32'h20 || b3.m_wdata !== 32'h5A) begin
        bad++; $display("FAIL wr_acc%0d: en=%b we=%b addr=%h wdata=%h want 1 1 20 5a", k, b3.m_en, b3.m_we, b3.m_addr, b3.m_wdata);
      end
      tick();
    end
    @(negedge clk); total++;
    if (b3.d_rvalid !== 1 || b3.c_rvalid !== 0 || b3.m_en !== 0 || b3.rdata !== 32'h12345678) begin
      bad++; $display("FAIL wr_resp: d_rv=%b c_rv=%b en=%b rdata=%h want 1 0 0 12345678", b3.d_rvalid, b3.c_rvalid, b3.m_en, b3.rdata);
    end
  endtask

  task automatic test_starve();
    string seq, want;
    int    n, cyc;
    want = "CCCCDCCCCD";
    seq = ""; n = 0; cyc = 0;
    do_reset();
    b3.c_req = 1; b3.d_req = 1; b3.c_addr = 32'h100; b3.d_addr = 32'h200;
    while (n < 10 && cyc < 80) begin
      @(negedge clk);
      if (b3.c_gnt || b3.d_gnt) begin
        total++;
        if (b3.c_gnt === b3.d_gnt || cyc != n * (L + 2) ||
            (b3.d_gnt ? "D" : "C") != want.substr(n, n)) begin
          bad++; $display("FAIL starve_g%0d: cyc=%0d c=%b d=%b want cyc=%0d %s", n, cyc, b3.c_gnt, b3.d_gnt, n * (L + 2), want.substr(n, n));
        end
        seq = {seq, b3.d_gnt ? "D" : "C"};
        n++;
      end
      tick(); cyc++;
    end
    total++;
    if (seq != want) begin
      bad++; $display("FAIL starve_seq: got %s want %s", seq, want);
    end
    idle_inputs();
  endtask

  task automatic test_simul();
    do_reset();
    b3.c_req = 1; b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h44;
    @(negedge clk); total++;
    if (b3.c_gnt !== 1 || b3.d_gnt !== 0) begin
      bad++; $display("FAIL simul_c0: c_gnt=%b d_gnt=%b want 1 0", b3.c_gnt, b3.d_gnt);
    end
    tick(); b3.c_req = 0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk); total++;
      if (b3.d_gnt !== (k == L + 2) || b3.c_gnt !== 0) begin
        bad++; $display("FAIL simul_c%0d: d_gnt=%b c_gnt=%b want %0d 0", k, b3.d_gnt, b3.c_gnt, k == L + 2);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_resp_req();
    do_reset();
    b3.c_req = 1; b3.c_addr = 32'h8;
    tick(); b3.c_req = 0;
    repeat (L) tick();
    b3.d_req = 1; b3.d_addr = 32'hC;
    @(negedge clk); total++;
    if (b3.c_rvalid !== 1 || b3.d_gnt !== 0) begin
      bad++; $display("FAIL respreq_resp: c_rv=%b d_gnt=%b want 1 0", b3.c_rvalid, b3.d_gnt);
    end
    tick();
    @(negedge clk); total++;
    if (b3.d_gnt !== 1 || b3.c_rvalid !== 0) begin
      bad++; $display("FAIL respreq_next: d_gnt=%b c_rv=%b want 1 0", b3.d_gnt, b3.c_rvalid);
    end
    tick(); idle_inputs();
    repeat (L + 2) tick();
  endtask

  task automatic test_rst_mid();
    bit seen;
    do_reset();
    b3.m_rdata = 32'hCAFEF00D;
    b3.c_req = 1; b3.c_addr = 32'h30;
    tick(); b3.c_req = 0;
    repeat (L + 1) tick();
    b3.c_req = 1; b3.c_we = 1; b3.c_addr = 32'h34; b3.c_wdata = 32'h77;
    tick(); b3.c_req = 0;
    tick();
    @(negedge clk); total++;
    if (b3.m_en !== 1 || b3.rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rstmid_pre: m_en=%b rdata=%h want 1 cafef00d", b3.m_en, b3.rdata);
    end
    b3.c_req = 1;
    #2 rst = 0;
    #1; total++;
    if ({b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we} !== 6'b0 ||
        b3.m_addr !== 0 || b3.m_wdata !== 0 || b3.rdata !== 0) begin
      bad++; $display("FAIL rstmid_async: ctl=%b addr=%h wdata=%h rdata=%h want all 0",
        {b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we}, b3.m_addr, b3.m_wdata, b3.rdata);
    end
    @(posedge clk); b3.c_req = 0;
    #1 rst = 1;
    seen = 0;
    repeat (L + 3) begin
      @(negedge clk);
      if (b3.c_rvalid || b3.d_rvalid || b3.m_en) seen = 1;
      tick();
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rstmid_drop: activity after reset seen=1 want 0");
    end
    b3.d_req = 1; b3.d_addr = 32'h50; b3.m_rdata = 32'h0BADF00D;
    @(negedge clk); total++;
    if (b3.d_gnt !== 1) begin
      bad++; $display("FAIL rstmid_regnt: d_gnt=%b want 1", b3.d_gnt);
    end
    tick(); b3.d_req = 0;
    repeat (L) tick();
    @(negedge clk); total++;
    if (b3.d_rvalid !== 1 || b3.rdata !== 32'h0BADF00D) begin
      bad++; $display("FAIL rstmid_resp: d_rv=%b rdata=%h want 1 0badf00d", b3.d_rvalid, b3.rdata);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    bit   c_seen, d_seen;
    c_seen = 0; d_seen = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i != 0) tick();
      if (c_seen) b3.c_req = 0;
      if (d_seen) b3.d_req = 0;
      if (!b3.c_req && $urandom_range(0, 2) == 0) begin
        b3.c_req = 1; b3.c_we = 1'($urandom); b3.c_addr = $urandom; b3.c_wdata = $urandom;
      end
      if (!b3.d_req && $urandom_range(0, 2) == 0) begin
        b3.d_req = 1; b3.d_we = 1'($urandom); b3.d_addr = $urandom; b3.d_wdata = $urandom;
      end
      b3.m_rdata = $urandom;
      @(negedge clk);
      model_step(e);
      c_seen = b3.c_gnt; d_seen = b3.d_gnt;
      total++;
      if ({b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we} !==
          {e.cg, e.dg, e.crv, e.drv, e.en, e.we}) begin
        bad++; $display("FAIL rand_ctl cyc=%0d: cg,dg,crv,drv,en,we=%b want %b", i,
          {b3.c_gnt, b3.d_gnt, b3.c_rvalid, b3.d_rvalid, b3.m_en, b3.m_we}, {e.cg, e.dg, e.crv, e.drv, e.en, e.we});
      end
      total++;
      if (b3.rdata !== e.rdata) begin
        bad++; $display("FAIL rand_rdata cyc=%0d: rdata=%h want %h", i, b3.rdata, e.rdata);
      end
      if (e.en) begin
        total++;
        if (b3.m_addr !== e.addr || b3.m_wdata !== e.wdata) begin
          bad++; $display("FAIL rand_bus cyc=%0d: addr=%h wdata=%h want %h %h", i, b3.m_addr, b3.m_wdata, e.addr, e.wdata);
        end
      end
    end
    tick(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lat1_read();
    test_ldr_write();
    test_starve();
    test_simul();
    test_resp_req();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
